// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Register addresses, status bit positions and FSM encoding.
package uart_tx_pkg;

    localparam logic [31:0] UART_DATA_ADDR = 32'h4000_0000;
    localparam logic [31:0] UART_STAT_ADDR = 32'h4000_0004;

    localparam int STAT_TX_ACTIVE = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_OVF       = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead output and occupancy count.
// Pushes into a full FIFO are dropped even if a pop happens alongside.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped 8N1 UART transmitter with transmit FIFO.
// Status register reports overflow, FIFO empty/full and line activity.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    tx_state_e   state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ovf_q, ovf_d;

    logic        fifo_push, fifo_pop;
    logic        fifo_full, fifo_empty;
    logic [7:0]  fifo_dout;
    logic        data_wr, stat_wr;
    logic        tx_active, baud_last;
    logic [3:0]  stat;
    logic        unused_wdata;

    assign data_wr      = we & (addr == UART_DATA_ADDR);
    assign stat_wr      = we & (addr == UART_STAT_ADDR);
    assign fifo_push    = data_wr & ~rst;
    assign unused_wdata = ^wdata[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign tx_active = (state_q != IDLE);
    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
    assign busy      = tx_active | ~fifo_empty;
    assign tx        = tx_q;

    // Overflow is sticky; only an explicit status write clears it.
    always_comb begin
        ovf_d = ovf_q;
        if (fifo_push & fifo_full) ovf_d = 1'b1;
        else if (stat_wr & wdata[3]) ovf_d = 1'b0;
    end

    always_comb begin
        stat                 = '0;
        stat[STAT_TX_ACTIVE] = tx_active;
        stat[STAT_FULL]      = fifo_full;
        stat[STAT_EMPTY]     = fifo_empty;
        stat[STAT_OVF]       = ovf_q;
        rdata = (addr == UART_STAT_ADDR) ? {28'b0, stat} : 32'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is derived from the next state so tx is registered.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit (legal range ≥2).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the transmit FIFO entry count (power of two, ≥2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port we, input, 1 bit: store strobe from the core, already qualified by the UART address decode.
REQ-006 The block SHALL have port addr, input, 32 bits: byte address of the store or status read.
REQ-007 The block SHALL have port wdata, input, 32 bits: store data; only bits [7:0] are transmitted.
REQ-008 The block SHALL have port rdata, output, 32 bits: combinational status word for reads.
REQ-009 The block SHALL have port tx, output, 1 bit: the serial line, registered, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is on the line or the FIFO is non-empty.

Function
REQ-011 A cycle with we=1 and addr=0x4000_0000 SHALL push wdata[7:0] into the FIFO if it is not full.
REQ-012 A push while the FIFO is full SHALL drop the byte and set the sticky overflow flag; this applies even when a pop occurs in the same cycle.
REQ-013 A cycle with we=1, addr=0x4000_0004 and wdata[3]=1 SHALL clear overflow; a push is unaffected by this.
REQ-014 rdata at addr=0x4000_0004 SHALL be {28'b0, overflow, fifo_empty, fifo_full, tx_active}; at any other addr it SHALL be 0.
REQ-015 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-016 IDLE: tx=1; when the FIFO is non-empty, pop one byte into the shift register and go to START.
REQ-017 START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
REQ-018 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first, 8 bits; after bit 7 go to STOP.
REQ-019 STOP: tx=1 for CLKS_PER_BIT cycles; at the end, if the FIFO is non-empty, pop and go directly to START (no idle cycle), else go to IDLE.
REQ-020 The baud counter SHALL count 0..CLKS_PER_BIT-1 and reset to 0 on every state or bit transition.
REQ-021 Latency: a push sampled at edge k into an empty FIFO with FSM in IDLE SHALL drive tx low after edge k+1.
REQ-022 One frame SHALL last exactly 10*CLKS_PER_BIT cycles (8N1).
REQ-023 tx_active SHALL be 1 in START, DATA and STOP; busy SHALL equal tx_active OR NOT fifo_empty.
REQ-024 The FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL be 0..FIFO_DEPTH, and full is defined as count==FIFO_DEPTH.
REQ-025 A simultaneous push and pop on a non-full FIFO SHALL both take effect, leaving the count unchanged.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL go to IDLE with tx=1, busy=0, FIFO empty, overflow=0, baud counter=0 and bit index=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, discard the FIFO contents, and drive tx high from the next edge.
REQ-028 While rst=1, pushes SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold UART_DATA_ADDR=0x4000_0000, UART_STAT_ADDR=0x4000_0004, the status bit positions (TX_ACTIVE=0, FULL=1, EMPTY=2, OVF=3), and the FSM state encoding.
REQ-030 The FIFO SHALL be a separate sub-module sync_fifo (parameters WIDTH, DEPTH; ports push/pop/din/dout/full/empty, synchronous active-high reset), instantiated once.

Verification
REQ-031 Bench: with CLKS_PER_BIT=4, write 0xA5 -> tx is low 1 cycle after the write, then shows bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high; the frame is 40 cycles and busy drops after it.
REQ-032 Bench: write 3 bytes back-to-back -> 3 contiguous frames (120 cycles at CLKS_PER_BIT=4) with no idle gap between stop and start.
REQ-033 Bench: with FIFO_DEPTH=8, write 10 bytes in consecutive cycles -> the first byte pops, 8 are queued, and 1 is dropped, so overflow=1 and status reads 0xB (overflow, full, active); exactly 9 frames are sent.
REQ-034 Bench: write wdata=0x8 to 0x4000_0004 -> overflow clears, and rdata bit3=0 on the next cycle.
REQ-035 Bench: assert rst mid-DATA -> tx=1 from the next edge, busy=0, status reads 0x4, and no further frames are sent.
REQ-036 Bench: write to 0x4000_0008 -> no push, no state change, and rdata=0.
